// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_pkg
// Purpose  : Shared encodings for the execute stage. Holds the ALU operation
//            codes, the branch funct3 codes and the operand-forwarding select
//            codes, plus the datapath width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package execute_stage_pkg;

    localparam int unsigned c_XLEN = 32;

    // ALU operation select; codes 11..15 are unused and produce zero
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // Branch comparison (funct3); 010/011 are never taken
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

    // Operand forwarding source; 11 falls back to the register value
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage : execute_stage_pkg
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Purpose  : Bundle of the execute-stage inputs (decode/execute register,
//            forwarding, hazard controls) and its outputs (fetch redirect and
//            memory-stage register).
// Modports : master - producer of the _E/control inputs, consumer of outputs
//            slave  - the execute stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface execute_stage_if;

    // decode/execute register
    logic        REG_W_En_E;
    logic        MEM_W_En_E;
    logic        Jump_En_E;
    logic        Branch_En_E;
    logic [2:0]  MEM_Control_E;
    logic [3:0]  ALU_Control_E;
    logic        Branch_Src_Sel_E;
    logic        ALU_SrcA_Sel_E;
    logic        ALU_SrcB_Sel_E;
    logic [1:0]  Result_Src_Sel_E;
    logic [4:0]  RD_E;
    logic [31:0] REG_R_Data1_E;
    logic [31:0] REG_R_Data2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PC_E;
    logic [31:0] PC_Plus_4_E;
    // forwarding and hazard control
    logic [1:0]  Fwd_A_Sel;
    logic [1:0]  Fwd_B_Sel;
    logic [31:0] Result_W;
    logic        Stall_M;
    logic        Flush_M;
    // fetch redirect
    logic        PC_Src_E;
    logic [31:0] PC_Target_E;
    logic        Misalign_E;
    // memory-stage register
    logic        REG_W_En_M;
    logic        MEM_W_En_M;
    logic [2:0]  MEM_Control_M;
    logic [1:0]  Result_Src_Sel_M;
    logic [4:0]  RD_M;
    logic [31:0] ALU_Result_M;
    logic [31:0] MEM_W_Data_M;
    logic [31:0] PC_Plus_4_M;
    logic        Exception_M;

    modport master (
        output REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E, MEM_Control_E,
               ALU_Control_E, Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E,
               Result_Src_Sel_E, RD_E, REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E,
               PC_E, PC_Plus_4_E, Fwd_A_Sel, Fwd_B_Sel, Result_W, Stall_M, Flush_M,
        input  PC_Src_E, PC_Target_E, Misalign_E, REG_W_En_M, MEM_W_En_M,
               MEM_Control_M, Result_Src_Sel_M, RD_M, ALU_Result_M, MEM_W_Data_M,
               PC_Plus_4_M, Exception_M
    );

    modport slave (
        input  REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E, MEM_Control_E,
               ALU_Control_E, Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E,
               Result_Src_Sel_E, RD_E, REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E,
               PC_E, PC_Plus_4_E, Fwd_A_Sel, Fwd_B_Sel, Result_W, Stall_M, Flush_M,
        output PC_Src_E, PC_Target_E, Misalign_E, REG_W_En_M, MEM_W_En_M,
               MEM_Control_M, Result_Src_Sel_M, RD_M, ALU_Result_M, MEM_W_Data_M,
               PC_Plus_4_M, Exception_M
    );

endinterface : execute_stage_if
`default_nettype wire

// File: rtl/execute_stage_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 32-bit combinational ALU of the execute stage.
// Ports    : i_src_a   in  32  operand A
//            i_src_b   in  32  operand B (shift amount taken from [4:0])
//            i_alu_ctl in   4  operation (alu_op_e encoding)
//            o_result  out 32  result; unused codes give zero
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import execute_stage_pkg::*;
(
    input  wire logic [c_XLEN-1:0] i_src_a,
    input  wire logic [c_XLEN-1:0] i_src_b,
    input  wire logic [3:0]        i_alu_ctl,
    output logic      [c_XLEN-1:0] o_result
);

    logic [4:0] w_shamt;
    assign w_shamt = i_src_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_alu_ctl)
            ALU_ADD:   o_result = i_src_a + i_src_b;
            ALU_SUB:   o_result = i_src_a - i_src_b;
            ALU_AND:   o_result = i_src_a & i_src_b;
            ALU_OR:    o_result = i_src_a | i_src_b;
            ALU_XOR:   o_result = i_src_a ^ i_src_b;
            ALU_SLL:   o_result = i_src_a << w_shamt;
            ALU_SRL:   o_result = i_src_a >> w_shamt;
            ALU_SRA:   o_result = $unsigned($signed(i_src_a) >>> w_shamt);
            ALU_SLT:   o_result = {31'd0, $signed(i_src_a) < $signed(i_src_b)};
            ALU_SLTU:  o_result = {31'd0, i_src_a < i_src_b};
            ALU_PASSB: o_result = i_src_b;
            default:   o_result = '0;
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Pipeline execute stage: operand forwarding, ALU, branch/jump
//            resolution with fetch redirect, and the memory-stage register.
// Ports    : CLK   in  1  rising-edge clock
//            RST_N in  1  asynchronous active-low reset (clears _M outputs)
//            ex    slave modport of execute_stage_if (all _E inputs,
//                  forwarding/hazard controls, redirect and _M outputs)
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage
    import execute_stage_pkg::*;
(
    input  wire logic      CLK,
    input  wire logic      RST_N,
    execute_stage_if.slave ex
);

    logic [c_XLEN-1:0] w_src_a_fwd;
    logic [c_XLEN-1:0] w_src_b_fwd;
    logic [c_XLEN-1:0] w_alu_a;
    logic [c_XLEN-1:0] w_alu_b;
    logic [c_XLEN-1:0] w_alu_result;
    logic [c_XLEN-1:0] w_jalr_sum;
    logic [c_XLEN-1:0] w_target;
    logic              w_cond;
    logic              w_pc_src;
    logic              w_misalign;

    logic              r_reg_w_en_m;
    logic              r_mem_w_en_m;
    logic [2:0]        r_mem_control_m;
    logic [1:0]        r_result_src_sel_m;
    logic [4:0]        r_rd_m;
    logic [c_XLEN-1:0] r_alu_result_m;
    logic [c_XLEN-1:0] r_mem_w_data_m;
    logic [c_XLEN-1:0] r_pc_plus_4_m;
    logic              r_exception_m;

    // Forwarding: the memory-stage source is this stage's own result register
    always_comb begin
        w_src_a_fwd = ex.REG_R_Data1_E;
        case (ex.Fwd_A_Sel)
            FWD_WB:  w_src_a_fwd = ex.Result_W;
            FWD_MEM: w_src_a_fwd = r_alu_result_m;
            default: w_src_a_fwd = ex.REG_R_Data1_E;
        endcase
    end

    always_comb begin
        w_src_b_fwd = ex.REG_R_Data2_E;
        case (ex.Fwd_B_Sel)
            FWD_WB:  w_src_b_fwd = ex.Result_W;
            FWD_MEM: w_src_b_fwd = r_alu_result_m;
            default: w_src_b_fwd = ex.REG_R_Data2_E;
        endcase
    end

    assign w_alu_a = ex.ALU_SrcA_Sel_E ? ex.PC_E      : w_src_a_fwd;
    assign w_alu_b = ex.ALU_SrcB_Sel_E ? ex.Imm_Ext_E : w_src_b_fwd;

    alu u_alu (
        .i_src_a   (w_alu_a),
        .i_src_b   (w_alu_b),
        .i_alu_ctl (ex.ALU_Control_E),
        .o_result  (w_alu_result)
    );

    // Branch compare always uses the forwarded register operands
    always_comb begin
        w_cond = 1'b0;
        case (ex.MEM_Control_E)
            BR_EQ:   w_cond = (w_src_a_fwd == w_src_b_fwd);
            BR_NE:   w_cond = (w_src_a_fwd != w_src_b_fwd);
            BR_LT:   w_cond = ($signed(w_src_a_fwd) <  $signed(w_src_b_fwd));
            BR_GE:   w_cond = ($signed(w_src_a_fwd) >= $signed(w_src_b_fwd));
            BR_LTU:  w_cond = (w_src_a_fwd <  w_src_b_fwd);
            BR_GEU:  w_cond = (w_src_a_fwd >= w_src_b_fwd);
            default: w_cond = 1'b0;
        endcase
    end

    // Register-relative targets (JALR) drop bit 0; bit 1 is left to flag misalignment
    assign w_jalr_sum = w_src_a_fwd + ex.Imm_Ext_E;
    assign w_target   = ex.Branch_Src_Sel_E ? {w_jalr_sum[c_XLEN-1:1], 1'b0}
                                            : (ex.PC_E + ex.Imm_Ext_E);
    assign w_pc_src   = ex.Jump_En_E | (ex.Branch_En_E & w_cond);
    assign w_misalign = w_pc_src & w_target[1];

    assign ex.PC_Src_E    = w_pc_src;
    assign ex.PC_Target_E = w_target;
    assign ex.Misalign_E  = w_misalign;

    // Flush kills only the side-effecting controls; data fields keep their value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_reg_w_en_m       <= 1'b0;
            r_mem_w_en_m       <= 1'b0;
            r_mem_control_m    <= '0;
            r_result_src_sel_m <= '0;
            r_rd_m             <= '0;
            r_alu_result_m     <= '0;
            r_mem_w_data_m     <= '0;
            r_pc_plus_4_m      <= '0;
            r_exception_m      <= 1'b0;
        end else if (ex.Flush_M) begin
            r_reg_w_en_m       <= 1'b0;
            r_mem_w_en_m       <= 1'b0;
            r_exception_m      <= 1'b0;
        end else if (!ex.Stall_M) begin
            r_reg_w_en_m       <= ex.REG_W_En_E & (ex.RD_E != 5'd0);
            r_mem_w_en_m       <= ex.MEM_W_En_E;
            r_mem_control_m    <= ex.MEM_Control_E;
            r_result_src_sel_m <= ex.Result_Src_Sel_E;
            r_rd_m             <= ex.RD_E;
            r_alu_result_m     <= w_alu_result;
            r_mem_w_data_m     <= w_src_b_fwd;
            r_pc_plus_4_m      <= ex.PC_Plus_4_E;
            r_exception_m      <= w_misalign;
        end
    end

    assign ex.REG_W_En_M       = r_reg_w_en_m;
    assign ex.MEM_W_En_M       = r_mem_w_en_m;
    assign ex.MEM_Control_M    = r_mem_control_m;
    assign ex.Result_Src_Sel_M = r_result_src_sel_m;
    assign ex.RD_M             = r_rd_m;
    assign ex.ALU_Result_M     = r_alu_result_m;
    assign ex.MEM_W_Data_M     = r_mem_w_data_m;
    assign ex.PC_Plus_4_M      = r_pc_plus_4_m;
    assign ex.Exception_M      = r_exception_m;

endmodule : execute_stage
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Self-checking bench for execute_stage. A driver applies directed
//            and random inputs on the falling edge and pushes the expected
//            redirect and memory-stage values from a reference model into a
//            queue; a monitor pops each entry and compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    execute_stage_if ex ();

    execute_stage dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ex    (ex)
    );

    typedef struct {
        logic        pc_src;
        logic [31:0] target;
        logic        mis;
        logic        reg_w;
        logic        mem_w;
        logic [2:0]  mctl;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic        exc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model of the memory-stage register contents
    logic        m_reg_w, m_mem_w, m_exc;
    logic [2:0]  m_mctl;
    logic [1:0]  m_rsrc;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wdata, m_pc4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_reg_w = 0; m_mem_w = 0; m_exc = 0; m_mctl = 0; m_rsrc = 0;
        m_rd = 0; m_alu = 0; m_wdata = 0; m_pc4 = 0;
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint      sa, sb;
        sh = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            8:  return (sa < sb) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input int f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            0: return a == b;
            1: return a != b;
            4: return sa < sb;
            5: return sa >= sb;
            6: return a < b;
            7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input int sel, input logic [31:0] reg_v);
        if (sel == 1) return ex.Result_W;
        if (sel == 2) return m_alu;
        return reg_v;
    endfunction

    // Compute expectations from the currently applied inputs and advance the model
    task automatic issue();
        exp_t        e;
        logic [31:0] sa, sb, opa, opb, alu_v;
        sa    = ref_fwd(int'(ex.Fwd_A_Sel), ex.REG_R_Data1_E);
        sb    = ref_fwd(int'(ex.Fwd_B_Sel), ex.REG_R_Data2_E);
        opa   = ex.ALU_SrcA_Sel_E ? ex.PC_E : sa;
        opb   = ex.ALU_SrcB_Sel_E ? ex.Imm_Ext_E : sb;
        alu_v = ref_alu(int'(ex.ALU_Control_E), opa, opb);
        e.pc_src = ex.Jump_En_E || (ex.Branch_En_E && ref_taken(int'(ex.MEM_Control_E), sa, sb));
        e.target = ex.Branch_Src_Sel_E ? ((sa + ex.Imm_Ext_E) & 32'hFFFF_FFFE)
                                       : (ex.PC_E + ex.Imm_Ext_E);
        e.mis    = e.pc_src && e.target[1];
        if (ex.Flush_M) begin
            m_reg_w = 0; m_mem_w = 0; m_exc = 0;
        end else if (!ex.Stall_M) begin
            m_reg_w = ex.REG_W_En_E && (ex.RD_E != 0);
            m_mem_w = ex.MEM_W_En_E;
            m_mctl  = ex.MEM_Control_E;
            m_rsrc  = ex.Result_Src_Sel_E;
            m_rd    = ex.RD_E;
            m_alu   = alu_v;
            m_wdata = sb;
            m_pc4   = ex.PC_Plus_4_E;
            m_exc   = e.mis;
        end
        e.reg_w = m_reg_w; e.mem_w = m_mem_w; e.mctl = m_mctl; e.rsrc = m_rsrc;
        e.rd = m_rd; e.alu = m_alu; e.wdata = m_wdata; e.pc4 = m_pc4; e.exc = m_exc;
        q.push_back(e);
    endtask

    task automatic clear_ctl();
        ex.REG_W_En_E = 0; ex.MEM_W_En_E = 0; ex.Jump_En_E = 0; ex.Branch_En_E = 0;
        ex.MEM_Control_E = 0; ex.ALU_Control_E = 0; ex.Branch_Src_Sel_E = 0;
        ex.ALU_SrcA_Sel_E = 0; ex.ALU_SrcB_Sel_E = 0; ex.Result_Src_Sel_E = 0;
        ex.RD_E = 0; ex.REG_R_Data1_E = 0; ex.REG_R_Data2_E = 0; ex.Imm_Ext_E = 0;
        ex.PC_E = 0; ex.PC_Plus_4_E = 0; ex.Fwd_A_Sel = 0; ex.Fwd_B_Sel = 0;
        ex.Result_W = 0; ex.Stall_M = 0; ex.Flush_M = 0;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        ex.REG_W_En_E       = 1'($urandom);
        ex.MEM_W_En_E       = 1'($urandom);
        ex.Jump_En_E        = ($urandom_range(0, 3) == 0);
        ex.Branch_En_E      = 1'($urandom);
        ex.MEM_Control_E    = 3'($urandom_range(0, 7));
        ex.ALU_Control_E    = 4'($urandom_range(0, 15));
        ex.Branch_Src_Sel_E = 1'($urandom);
        ex.ALU_SrcA_Sel_E   = 1'($urandom);
        ex.ALU_SrcB_Sel_E   = 1'($urandom);
        ex.Result_Src_Sel_E = 2'($urandom);
        ex.RD_E             = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        ex.REG_R_Data1_E    = rnd32();
        ex.REG_R_Data2_E    = ($urandom_range(0, 3) == 0) ? ex.REG_R_Data1_E : rnd32();
        ex.Imm_Ext_E        = rnd32();
        ex.PC_E             = $urandom;
        ex.PC_Plus_4_E      = ex.PC_E + 32'd4;
        ex.Fwd_A_Sel        = 2'($urandom_range(0, 3));
        ex.Fwd_B_Sel        = 2'($urandom_range(0, 3));
        ex.Result_W         = rnd32();
        ex.Stall_M          = ($urandom_range(0, 5) == 0);
        ex.Flush_M          = ($urandom_range(0, 7) == 0);
    endtask

    // Pulse reset low between clock edges; outputs must clear immediately
    task automatic reset_pulse(input string tag);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk({tag, "_reg_w"}, 32'(ex.REG_W_En_M), 0);
        chk({tag, "_mem_w"}, 32'(ex.MEM_W_En_M), 0);
        chk({tag, "_mctl"},  32'(ex.MEM_Control_M), 0);
        chk({tag, "_rsrc"},  32'(ex.Result_Src_Sel_M), 0);
        chk({tag, "_rd"},    32'(ex.RD_M), 0);
        chk({tag, "_alu"},   ex.ALU_Result_M, 0);
        chk({tag, "_wdata"}, ex.MEM_W_Data_M, 0);
        chk({tag, "_pc4"},   ex.PC_Plus_4_M, 0);
        chk({tag, "_exc"},   32'(ex.Exception_M), 0);
        #1;
        RST_N = 1'b1;
        model_zero();
    endtask

    // Monitor: redirect outputs sampled before the edge, register outputs after it
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_src",    32'(ex.PC_Src_E), 32'(e.pc_src));
                chk("pc_target", ex.PC_Target_E,   e.target);
                chk("misalign",  32'(ex.Misalign_E), 32'(e.mis));
                @(posedge CLK);
                #1;
                chk("reg_w_en_m",  32'(ex.REG_W_En_M),       32'(e.reg_w));
                chk("mem_w_en_m",  32'(ex.MEM_W_En_M),       32'(e.mem_w));
                chk("mem_ctl_m",   32'(ex.MEM_Control_M),    32'(e.mctl));
                chk("res_src_m",   32'(ex.Result_Src_Sel_M), 32'(e.rsrc));
                chk("rd_m",        32'(ex.RD_M),             32'(e.rd));
                chk("alu_result_m", ex.ALU_Result_M,         e.alu);
                chk("mem_wdata_m", ex.MEM_W_Data_M,          e.wdata);
                chk("pc_plus_4_m", ex.PC_Plus_4_M,           e.pc4);
                chk("exception_m", 32'(ex.Exception_M),      32'(e.exc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        clear_ctl();
        model_zero();
        #2;
        chk("reset_reg_w", 32'(ex.REG_W_En_M), 0);
        chk("reset_mem_w", 32'(ex.MEM_W_En_M), 0);
        chk("reset_alu",   ex.ALU_Result_M, 0);
        chk("reset_exc",   32'(ex.Exception_M), 0);
        #10;
        RST_N = 1'b1;

        // ADD wraps into the sign bit
        @(negedge CLK); clear_ctl();
        ex.ALU_Control_E = 4'd0; ex.REG_R_Data1_E = 32'h7FFF_FFFF;
        ex.ALU_SrcB_Sel_E = 1; ex.Imm_Ext_E = 32'd1; ex.REG_W_En_E = 1; ex.RD_E = 5'd3;
        issue();
        // SRA uses only the low five bits of B
        @(negedge CLK); clear_ctl();
        ex.ALU_Control_E = 4'd7; ex.REG_R_Data1_E = 32'h8000_0000;
        ex.ALU_SrcB_Sel_E = 1; ex.Imm_Ext_E = 32'h24;
        issue();
        // BLT taken, then BLTU not taken on the same operands
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK); clear_ctl();
            ex.Branch_En_E = 1; ex.MEM_Control_E = (k == 0) ? 3'b100 : 3'b110;
            ex.REG_R_Data1_E = 32'hFFFF_FFFF; ex.REG_R_Data2_E = 32'd1;
            ex.PC_E = 32'h100; ex.Imm_Ext_E = 32'hFFFF_FFF8;
            issue();
        end
        // Preload ALU_Result_M = 0x2003, then JALR forwarding from it
        @(negedge CLK); clear_ctl();
        ex.ALU_Control_E = 4'd10; ex.ALU_SrcB_Sel_E = 1; ex.Imm_Ext_E = 32'h2003;
        issue();
        @(negedge CLK); clear_ctl();
        ex.Jump_En_E = 1; ex.Branch_Src_Sel_E = 1; ex.Fwd_A_Sel = 2'b10;
        ex.Imm_Ext_E = 32'd4; ex.REG_W_En_E = 1; ex.RD_E = 5'd1;
        issue();
        // RD=0 suppresses write enable; stall holds; stall+flush flushes
        @(negedge CLK); clear_ctl();
        ex.REG_W_En_E = 1; ex.RD_E = 5'd0; ex.MEM_W_En_E = 1; ex.PC_Plus_4_E = 32'h44;
        issue();
        @(negedge CLK); clear_ctl();
        ex.REG_W_En_E = 1; ex.RD_E = 5'd5; ex.Stall_M = 1; ex.PC_Plus_4_E = 32'h88;
        ex.REG_R_Data1_E = 32'h1234;
        issue();
        @(negedge CLK); clear_ctl();
        ex.REG_W_En_E = 1; ex.RD_E = 5'd5; ex.Stall_M = 1; ex.Flush_M = 1;
        ex.MEM_W_En_E = 1;
        issue();
        // Reset pulse right after a store was loaded
        @(negedge CLK); clear_ctl();
        ex.MEM_W_En_E = 1; ex.REG_W_En_E = 1; ex.RD_E = 5'd7; ex.PC_Plus_4_E = 32'h10;
        ex.REG_R_Data2_E = 32'hDEAD_BEEF;
        issue();
        reset_pulse("rst_after_load");
        // First edge after release loads normally
        @(negedge CLK); rand_inputs(); ex.Stall_M = 0; ex.Flush_M = 0;
        issue();
        // Reset pulse during a stall
        @(negedge CLK); clear_ctl();
        ex.MEM_W_En_E = 1; ex.RD_E = 5'd9; ex.REG_W_En_E = 1;
        issue();
        @(negedge CLK); rand_inputs(); ex.Stall_M = 1; ex.Flush_M = 0;
        issue();
        reset_pulse("rst_mid_stall");

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            rand_inputs();
            issue();
            if (i % 137 == 136) reset_pulse("rst_random");
        end

        repeat (2) @(posedge CLK);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_execute_stage
`default_nettype wire
